// File: rtl/soma_multiplica_param_pkg.sv
// Shared definitions for the soma_multiplica_param slice.
//   op_e    : operation codes carried on the 2-bit op field
//   state_e : control FSM states of the top level
//   is_iterative() : true for the ops that run through the shift-add engine
package soma_multiplica_param_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_MAC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_iterative(input op_e op);
    return (op == OP_MUL) || (op == OP_MAC);
  endfunction

endpackage

// File: rtl/soma_multiplica_param_if.sv
// Operand/result handshake bundle for soma_multiplica_param.
//   master : operand producer + result consumer (drives in_valid, op, a, b,
//            acc_clr, out_ready)
//   slave  : the arithmetic unit (drives in_ready, out_valid, result, ovf, acc)
interface soma_multiplica_param_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         ovf;
  logic [W-1:0] acc;

  modport master (
    output in_valid, op, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, result, ovf, acc
  );

  modport slave (
    input  in_valid, op, a, b, acc_clr, out_ready,
    output in_ready, out_valid, result, ovf, acc
  );
endinterface

// File: rtl/soma_multiplica_param_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per clock, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and clear the partial product (one-cycle pulse)
//   a, b       : W-bit unsigned multiplicand / multiplier
//   done       : high during the cycle whose rising edge completes the W-th
//                iteration; product is the final value during that cycle
//   product    : 2W-bit partial product including the current iteration
module soma_multiplica_param_seq_mul #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CNT_W = $clog2(W) + 1;

  logic [2*W-1:0]   mcand_reg;
  logic [W-1:0]     mplier_reg;
  logic [2*W-1:0]   partial_reg;
  logic [2*W-1:0]   partial_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;

  // The multiplicand is pre-shifted each iteration and the multiplier
  // shifted down, so the current bit is always mplier_reg[0].
  assign partial_next = mplier_reg[0] ? (partial_reg + mcand_reg) : partial_reg;

  // Exposing the combinational sum lets the caller capture the result on the
  // same edge as the last iteration, giving a latency of exactly W edges.
  assign done    = busy_reg && (cnt_reg == CNT_W'(W - 1));
  assign product = partial_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      partial_reg <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
    end else if (start) begin
      mcand_reg   <= {{W{1'b0}}, a};
      mplier_reg  <= b;
      partial_reg <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b1;
    end else if (busy_reg) begin
      partial_reg <= partial_next;
      mcand_reg   <= mcand_reg << 1;
      mplier_reg  <= mplier_reg >> 1;
      cnt_reg     <= cnt_reg + CNT_W'(1);
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/soma_multiplica_param.sv
// Handshaked add / sub / multiply / multiply-accumulate unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of soma_multiplica_param_if
//                in_valid/in_ready accept op, a, b (in_ready only in IDLE);
//                acc_clr clears the accumulator while IDLE;
//                out_valid/out_ready hand over result, ovf; acc is the
//                running accumulator.
// add/sub finish on the accept edge; mul/mac take W edges in seq_mul.
module soma_multiplica_param
  import soma_multiplica_param_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  soma_multiplica_param_if.slave bus
);
  state_e         state_reg, state_next;
  op_e            op_reg;
  op_e            op_in;
  logic [W-1:0]   result_reg;
  logic [W-1:0]   acc_reg;
  logic           ovf_reg;

  logic           accept;
  logic           start_mul;
  logic           mul_done;
  logic [2*W-1:0] product;
  logic [W:0]     add_sum;
  logic [W:0]     sub_diff;
  logic [W:0]     mac_sum;
  logic [W-1:0]   iter_result;
  logic           iter_ovf;

  assign op_in     = op_e'(bus.op);
  assign accept    = bus.in_valid && (state_reg == IDLE);
  assign start_mul = accept && is_iterative(op_in);

  // One extra bit holds the carry (add) or the borrow (sub: a<b wraps
  // the (W+1)-bit difference negative, setting its top bit).
  assign add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_diff = {1'b0, bus.a} - {1'b0, bus.b};
  assign mac_sum  = {1'b0, acc_reg} + {1'b0, product[W-1:0]};

  soma_multiplica_param_seq_mul #(.W(W)) u_seq_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_mul),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    iter_result = product[W-1:0];
    iter_ovf    = |product[2*W-1:W];
    if (op_reg == OP_MAC) begin
      iter_result = mac_sum[W-1:0];
      iter_ovf    = (|product[2*W-1:W]) | mac_sum[W];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = is_iterative(op_in) ? BUSY : DONE;
      BUSY:    if (mul_done) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= OP_ADD;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      acc_reg    <= '0;
    end else begin
      // A clear on the same edge as a mac accept is seen by the mac, since
      // the mac only reads acc_reg W edges later.
      if ((state_reg == IDLE) && bus.acc_clr) begin
        acc_reg <= '0;
      end
      if (accept) begin
        op_reg <= op_in;
        if (op_in == OP_ADD) begin
          result_reg <= add_sum[W-1:0];
          ovf_reg    <= add_sum[W];
        end else if (op_in == OP_SUB) begin
          result_reg <= sub_diff[W-1:0];
          ovf_reg    <= sub_diff[W];
        end
      end
      if ((state_reg == BUSY) && mul_done) begin
        result_reg <= iter_result;
        ovf_reg    <= iter_ovf;
        if (op_reg == OP_MAC) begin
          acc_reg <= iter_result;
        end
      end
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = result_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.acc       = acc_reg;
endmodule

// File: tb/tb_soma_multiplica_param.sv
// Self-checking bench for soma_multiplica_param: directed cases, randomized
// transactions against an arithmetic reference model, mid-operation reset,
// and a W=8 instance.
module tb_soma_multiplica_param;
  localparam int W  = 16;
  localparam int W8 = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soma_multiplica_param_if #(.W(W))  bus16 ();
  soma_multiplica_param_if #(.W(W8)) bus8 ();

  soma_multiplica_param #(.W(W)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  soma_multiplica_param #(.W(W8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  longint unsigned model_acc16 = 0;
  longint unsigned model_acc8  = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference arithmetic: full-precision result, then reduce mod 2^w.
  // Overflow is simply "the exact result does not fit in w bits".
  function automatic void model(input int w, input logic [1:0] op,
                                input longint unsigned a, input longint unsigned b,
                                input longint unsigned acc_in,
                                output longint unsigned res, output bit ovf,
                                output longint unsigned acc_out);
    longint unsigned m;
    longint unsigned full;
    m       = 64'd1 << w;
    acc_out = acc_in;
    full    = 0;
    case (op)
      2'd0: begin full = a + b; res = full % m; ovf = (full >= m); end
      2'd1: begin res = (a + m - b) % m; ovf = (a < b); end
      2'd2: begin full = a * b; res = full % m; ovf = (full >= m); end
      default: begin
        full = acc_in + a * b; res = full % m; ovf = (full >= m); acc_out = res;
      end
    endcase
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Entered at posedge+1 with the unit idle; leaves it idle at posedge+1.
  task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit clr, input int hold);
    longint unsigned exp_res, exp_acc;
    bit exp_ovf, quiet_ok, stable;
    int k;
    check("idle_in_ready", bus16.in_ready, 1);
    bus16.in_valid = 1'b1;
    bus16.op       = op;
    bus16.a        = a;
    bus16.b        = b;
    bus16.acc_clr  = clr;
    if (clr) model_acc16 = 0;
    model(W, op, a, b, model_acc16, exp_res, exp_ovf, exp_acc);
    model_acc16 = exp_acc;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    bus16.acc_clr  = 1'b0;
    k = 0;
    quiet_ok = 1'b1;
    while (!bus16.out_valid && k < 100) begin
      if (bus16.in_ready) quiet_ok = 1'b0;
      // Everything driven while BUSY must be ignored
      bus16.a        = 16'($urandom);
      bus16.b        = 16'($urandom);
      bus16.op       = 2'($urandom);
      bus16.acc_clr  = 1'($urandom);
      bus16.in_valid = 1'($urandom);
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, (op >= 2) ? W : 0);
    if (op >= 2) check("busy_in_ready_low", quiet_ok, 1);
    check("result", bus16.result, exp_res);
    check("ovf", bus16.ovf, exp_ovf);
    check("acc", bus16.acc, model_acc16);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus16.in_valid = 1'b1;
      bus16.a        = 16'($urandom);
      bus16.b        = 16'($urandom);
      bus16.op       = 2'($urandom);
      bus16.acc_clr  = 1'($urandom);
      @(posedge clk); #1;
      if (!bus16.out_valid || bus16.result != exp_res[15:0] || bus16.ovf != exp_ovf ||
          bus16.acc != model_acc16[15:0] || bus16.in_ready) stable = 1'b0;
    end
    if (hold > 0) check("done_hold", stable, 1);
    bus16.in_valid  = 1'b0;
    bus16.acc_clr   = 1'b0;
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    check("out_valid_clear", bus16.out_valid, 0);
    check("in_ready_back", bus16.in_ready, 1);
    $display("W16 op=%0d a=%h b=%h clr=%0d hold=%0d -> result=%h ovf=%0d acc=%h lat=%0d",
             op, a, b, clr, hold, exp_res[15:0], exp_ovf, model_acc16[15:0], k);
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    longint unsigned exp_res, exp_acc;
    bit exp_ovf;
    int k;
    model(W8, op, a, b, model_acc8, exp_res, exp_ovf, exp_acc);
    model_acc8 = exp_acc;
    bus8.in_valid = 1'b1;
    bus8.op       = op;
    bus8.a        = a;
    bus8.b        = b;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    k = 0;
    while (!bus8.out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("w8_latency", k, (op >= 2) ? W8 : 0);
    check("w8_result", bus8.result, exp_res);
    check("w8_ovf", bus8.ovf, exp_ovf);
    check("w8_acc", bus8.acc, model_acc8);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    check("w8_in_ready_back", bus8.in_ready, 1);
    $display("W8  op=%0d a=%h b=%h -> result=%h ovf=%0d acc=%h lat=%0d",
             op, a, b, exp_res[7:0], exp_ovf, model_acc8[7:0], k);
  endtask

  initial begin
    bus16.in_valid = 1'b0; bus16.op = 2'd0; bus16.a = '0; bus16.b = '0;
    bus16.acc_clr = 1'b0;  bus16.out_ready = 1'b0;
    bus8.in_valid = 1'b0;  bus8.op = 2'd0;  bus8.a = '0;  bus8.b = '0;
    bus8.acc_clr = 1'b0;   bus8.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus16.out_valid, 0);
    check("rst_result", bus16.result, 0);
    check("rst_ovf", bus16.ovf, 0);
    check("rst_acc", bus16.acc, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", bus16.in_ready, 1);

    // Directed cases
    run16(2'd0, 16'd2, 16'd3, 1'b0, 0);
    run16(2'd2, 16'd2, 16'd3, 1'b0, 0);
    run16(2'd2, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    run16(2'd1, 16'd3, 16'd5, 1'b0, 0);
    run16(2'd3, 16'd2, 16'd3, 1'b1, 0);
    run16(2'd3, 16'd4, 16'd5, 1'b0, 0);
    run16(2'd3, 16'd1, 16'd1, 1'b1, 0);
    run16(2'd0, 16'hFFFF, 16'd1, 1'b0, 5);
    run16(2'd2, 16'h1234, 16'd0, 1'b0, 0);
    run16(2'd3, 16'hFFFF, 16'hFFFF, 1'b0, 2);

    // Randomized transactions
    repeat (30) begin
      run16(2'($urandom_range(0, 3)), pick16(), pick16(),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    // Reset in the middle of a multiply
    run16(2'd3, 16'd3, 16'd3, 1'b1, 0);
    bus16.in_valid = 1'b1;
    bus16.op = 2'd2; bus16.a = 16'd2; bus16.b = 16'd3;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus16.out_valid, 0);
    check("midrst_acc", bus16.acc, 0);
    check("midrst_result", bus16.result, 0);
    model_acc16 = 0;
    model_acc8  = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", bus16.in_ready, 1);
    check("midrst_w8_in_ready", bus8.in_ready, 1);
    run16(2'd2, 16'd7, 16'd9, 1'b0, 0);

    // W = 8 instance
    run8(2'd2, 8'd15, 8'd17);
    run8(2'd2, 8'd16, 8'd16);
    run8(2'd0, 8'd200, 8'd100);
    run8(2'd1, 8'd1, 8'd2);
    run8(2'd3, 8'd10, 8'd10);
    run8(2'd3, 8'd12, 8'd13);
    repeat (6) run8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/soma_multiplica_param.md
Name: soma_multiplica_param

Overview:
Parametrised, handshaked successor of the registered add/multiply unit. Accepts two W-bit unsigned operands and a 2-bit op (add, sub, multiply, multiply-accumulate). Add/sub complete in one cycle; multiply and MAC use an iterative shift-add engine taking W cycles. Sits between an operand producer and a result consumer using valid/ready on both sides.

Parameters:
W, 16, operand/result width in bits (>= 4).
CNT_W, $clog2(W)+1, iteration counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid
in_ready  output  1  unit can accept (high only in IDLE)
op  input  2  00 add, 01 sub, 10 mul, 11 mac
a  input  W  operand A (unsigned)
b  input  W  operand B (unsigned)
acc_clr  input  1  clear accumulator (sampled in IDLE)
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  W  low W bits of the operation
ovf  output  1  overflow/borrow flag for result
acc  output  W  current accumulator value

Behaviour:
- Reset (async, rst_n=0): state IDLE, out_valid=0, result=0, ovf=0, acc=0, counter=0, in_ready=1 once rst_n deasserts. In-flight operation discarded.
- States: IDLE, BUSY, DONE. in_ready = (state==IDLE).
- Accept = in_valid & in_ready at a rising edge; a, b, op captured.
- IDLE, add/sub accepted: result, ovf registered at that edge; -> DONE (out_valid visible the next cycle, latency 1).
- IDLE, mul/mac accepted: load multiplicand=a, multiplier=b, partial=0 (2W bits), counter=0; -> BUSY.
- BUSY: one bit of b per edge (LSB first): if bit set, partial += a << counter; counter++. After W-th iteration edge -> DONE with result/ovf written on that edge. out_valid rises W edges after the acceptance edge.
- DONE: out_valid=1; result, ovf, acc held stable. out_ready=1 at edge -> IDLE, out_valid=0. out_ready may be held low indefinitely; no new accept while DONE.
- Arithmetic (all unsigned, result = low W bits):
  add: ovf = carry out of a+b.
  sub: result = a-b mod 2^W; ovf = (a<b).
  mul: ovf = (product[2W-1:W] != 0).
  mac: sum = acc + product; result = sum low W; acc <= result on DONE entry; ovf = product high half nonzero OR carry of sum.
- acc only changes on mac completion or acc_clr. acc_clr in IDLE clears acc at that edge (acc_clr ignored outside IDLE). acc_clr together with an accepted mac: clear takes priority, mac uses acc=0.
- op/a/b changes while BUSY/DONE have no effect.
- b=0 mul still takes W cycles (fixed latency; no early exit).

Decomposition:
- Shared package: op encodings (OP_ADD, OP_SUB, OP_MUL, OP_MAC), state enum (IDLE, BUSY, DONE).
- One sub-module: seq_mul (start, a, b -> done, product 2W bits, W-cycle shift-add); top holds FSM, add/sub path, accumulator, output registers.

Test Plan:
- add a=2, b=3 -> out_valid the cycle after accept, result=5, ovf=0; in_ready low exactly one cycle plus DONE time.
- mul a=2, b=3 (W=16) -> out_valid rises 16 edges after accept, result=6, ovf=0; in_ready=0 and out_valid=0 throughout BUSY.
- mul a=0xFFFF, b=0xFFFF -> result=0x0001, ovf=1; sub a=3, b=5 -> result=0xFFFE, ovf=1.
- acc_clr, then mac 2*3 -> result=6, acc=6; mac 4*5 -> result=26, acc=26; acc_clr with mac 1*1 same edge -> result=1, acc=1.
- out_ready low 5 cycles in DONE -> result/out_valid held, in_valid ignored; out_ready high -> IDLE next edge, in_ready=1.
- rst_n low mid-BUSY (iteration 7) -> immediately out_valid=0, acc=0, result=0; after release in_ready=1; repeat with W=8: mul 15*17 -> 255, ovf=0.
